procyon_fifo_wr_arb: RTL and testbench

Round-robin write arbiter that shares one procyon_sync_fifo write port between OPTN_NUM_REQ requesters. Supports locked bursts: a winning requester keeps the port for up to OPTN_BURST_LEN beats or until it marks the last beat. Sits directly in front of the FIFO write interface. Drives i_fifo_we/i_fifo_data and consumes o_fifo_full.

---
 rtl/procyon_fifo_wr_arb.sv | 107 ++++++++++
 tb/tb_procyon_fifo_wr_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/procyon_fifo_wr_arb.sv
// procyon_fifo_wr_arb: round-robin arbiter sharing one FIFO write port, with locked bursts.
// Define PCYN_FIFO_WR_ARB_STATS_EN to add per-requester accepted-beat counters on o_beat_cnt.
module procyon_fifo_wr_arb #(
    parameter int OPTN_NUM_REQ    = 4,
    parameter int OPTN_DATA_WIDTH = 8,
    parameter int OPTN_BURST_LEN  = 4
) (
    input  logic                                    clk,
    input  logic                                    n_rst,
    input  logic                                    i_flush,
    input  logic [OPTN_NUM_REQ-1:0]                 i_req_valid,
    input  logic [OPTN_NUM_REQ*OPTN_DATA_WIDTH-1:0] i_req_data,
    input  logic [OPTN_NUM_REQ-1:0]                 i_req_last,
    output logic [OPTN_NUM_REQ-1:0]                 o_req_ready,
    output logic                                    o_fifo_we,
    output logic [OPTN_DATA_WIDTH-1:0]              o_fifo_data,
    input  logic                                    i_fifo_full,
    output logic [$clog2(OPTN_NUM_REQ)-1:0]         o_grant_idx,
`ifdef PCYN_FIFO_WR_ARB_STATS_EN
    output logic [OPTN_NUM_REQ*16-1:0]              o_beat_cnt,
`endif
    output logic                                    o_locked
);
    localparam int IW = $clog2(OPTN_NUM_REQ);
    localparam int BW = $clog2(OPTN_BURST_LEN + 1);

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_idx;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] next_ptr;
    logic [BW-1:0] beat_cnt;
    logic          sel_found;
    logic          grant_valid;
    logic          last_beat;

    // Scan downward so the last hit is the one closest to rr_ptr.
    always_comb begin
        sel_idx   = rr_ptr;
        sel_found = 1'b0;
        scan_idx  = '0;
        for (int i = OPTN_NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = IW'((int'(rr_ptr) + i) % OPTN_NUM_REQ);
            if (i_req_valid[scan_idx]) begin
                sel_idx   = scan_idx;
                sel_found = 1'b1;
            end
        end
    end

    assign o_locked    = (state == ARB_BURST);
    assign o_grant_idx = o_locked ? lock_idx : (sel_found ? sel_idx : grant_q);
    assign grant_valid = o_locked ? i_req_valid[lock_idx] : sel_found;
    assign o_fifo_we   = grant_valid & ~i_fifo_full & ~i_flush;
    assign o_req_ready = o_fifo_we ? (OPTN_NUM_REQ'(1) << o_grant_idx) : '0;
    assign o_fifo_data = o_fifo_we ? i_req_data[int'(o_grant_idx)*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH] : '0;
    assign last_beat   = i_req_last[o_grant_idx];
    assign next_ptr    = IW'((int'(o_grant_idx) + 1) % OPTN_NUM_REQ);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            beat_cnt <= '0;
            grant_q  <= '0;
        end else begin
            grant_q <= o_grant_idx;
            if (i_flush) begin
                state    <= ARB_IDLE;
                beat_cnt <= '0;
            end else if (o_fifo_we) begin
                if (state == ARB_IDLE) begin
                    if (last_beat || OPTN_BURST_LEN == 1) begin
                        rr_ptr <= next_ptr;
                    end else begin
                        state    <= ARB_BURST;
                        lock_idx <= o_grant_idx;
                        beat_cnt <= BW'(1);
                    end
                end else if (last_beat || beat_cnt == BW'(OPTN_BURST_LEN - 1)) begin
                    state    <= ARB_IDLE;
                    beat_cnt <= '0;
                    rr_ptr   <= next_ptr;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

`ifdef PCYN_FIFO_WR_ARB_STATS_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_beat_cnt <= '0;
        end else begin
            for (int k = 0; k < OPTN_NUM_REQ; k++) begin
                if (o_req_ready[k]) o_beat_cnt[k*16 +: 16] <= o_beat_cnt[k*16 +: 16] + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_procyon_fifo_wr_arb.sv
// tb_procyon_fifo_wr_arb: directed stimulus with a scoreboard queue of expected FIFO writes.
`timescale 1ns/1ps
module tb_procyon_fifo_wr_arb;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic           i_flush = 1'b0;
    logic           i_fifo_full = 1'b0;
    logic [N-1:0]   i_req_valid = '0;
    logic [N-1:0]   i_req_last = '0;
    logic [N*W-1:0] i_req_data = '0;
    logic [N-1:0]   o_req_ready;
    logic           o_fifo_we;
    logic [W-1:0]   o_fifo_data;
    logic [1:0]     o_grant_idx;
    logic           o_locked;
`ifdef PCYN_FIFO_WR_ARB_STATS_EN
    logic [N*16-1:0] o_beat_cnt;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {int idx; int data;} beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    procyon_fifo_wr_arb #(.OPTN_NUM_REQ(N), .OPTN_DATA_WIDTH(W), .OPTN_BURST_LEN(4)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .i_flush(i_flush),
        .i_req_valid(i_req_valid),
        .i_req_data(i_req_data),
        .i_req_last(i_req_last),
        .o_req_ready(o_req_ready),
        .o_fifo_we(o_fifo_we),
        .o_fifo_data(o_fifo_data),
        .i_fifo_full(i_fifo_full),
        .o_grant_idx(o_grant_idx),
`ifdef PCYN_FIFO_WR_ARB_STATS_EN
        .o_beat_cnt(o_beat_cnt),
`endif
        .o_locked(o_locked)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_beat(input int idx, input int data);
        beat_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Advance one cycle, apply inputs, then settle so callers can check combinational outputs.
    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                        input logic fl, input logic fu);
        @(posedge clk);
        #2;
        i_req_valid = v;
        i_req_last  = l;
        i_req_data  = d;
        i_flush     = fl;
        i_fifo_full = fu;
        #1;
    endtask

    // Scoreboard monitor: every write the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        beat_t e;
        if (n_rst && o_fifo_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {30'd0, o_grant_idx}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("grant_idx", {30'd0, o_grant_idx}, e.idx);
                chk("fifo_data", {24'd0, o_fifo_data}, e.data);
                chk("req_ready", {28'd0, o_req_ready}, 32'd1 << e.idx);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", {28'd0, o_req_ready}, 0);
        chk("rst_we", {31'd0, o_fifo_we}, 0);
        chk("rst_data", {24'd0, o_fifo_data}, 0);
        chk("rst_grant", {30'd0, o_grant_idx}, 0);
        chk("rst_locked", {31'd0, o_locked}, 0);
        n_rst = 1'b1;

        // Round robin over four single-beat requesters
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 4'hF, 32'hA3A2_A1A0, 1'b0, 1'b0);
            expect_beat(i % 4, 8'hA0 + i % 4);
            chk("t1_locked", {31'd0, o_locked}, 0);
        end
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk("t1_idle_we", {31'd0, o_fifo_we}, 0);

        // Req1 six-beat burst truncated at four, then others served before it returns
        for (int b = 1; b <= 7; b++) begin
            d1 = (b <= 4) ? 8'(8'h10 + b) : 8'h15;
            step(4'hF, 4'b1101, {8'hA3, 8'hA2, d1, 8'hA0}, 1'b0, 1'b0);
            if (b <= 4) expect_beat(1, d1);
            else expect_beat((b - 3) % 4, 8'hA0 + (b - 3) % 4);
            chk("t2_locked", {31'd0, o_locked}, (b >= 2 && b <= 4) ? 1 : 0);
        end
        step(4'hF, 4'b1101, 32'hA3A2_15A0, 1'b0, 1'b0);
        expect_beat(1, 8'h15);
        chk("t2_b5_locked", {31'd0, o_locked}, 0);
        step(4'hF, 4'hF, 32'hA3A2_16A0, 1'b0, 1'b0);
        expect_beat(1, 8'h16);
        chk("t2_b6_locked", {31'd0, o_locked}, 1);
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk("t2_end_locked", {31'd0, o_locked}, 0);

        // Req0 burst stalled by a full FIFO, count must resume at two
        step(4'b0011, 4'b0010, 32'h0000_B120, 1'b0, 1'b0);
        expect_beat(0, 8'h20);
        step(4'b0011, 4'b0010, 32'h0000_B121, 1'b0, 1'b0);
        expect_beat(0, 8'h21);
        chk("t3_locked", {31'd0, o_locked}, 1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 4'b0010, 32'h0000_B122, 1'b0, 1'b1);
            chk("t3_full_we", {31'd0, o_fifo_we}, 0);
            chk("t3_full_ready", {28'd0, o_req_ready}, 0);
            chk("t3_full_locked", {31'd0, o_locked}, 1);
            chk("t3_full_grant", {30'd0, o_grant_idx}, 0);
        end
        step(4'b0011, 4'b0010, 32'h0000_B122, 1'b0, 1'b0);
        expect_beat(0, 8'h22);
        step(4'b0011, 4'b0010, 32'h0000_B123, 1'b0, 1'b0);
        expect_beat(0, 8'h23);
        chk("t3_b4_locked", {31'd0, o_locked}, 1);
        step(4'b0011, 4'b0010, 32'h0000_B124, 1'b0, 1'b0);
        expect_beat(1, 8'hB1);
        chk("t3_after_locked", {31'd0, o_locked}, 0);
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);

        // Flush aborts req3 burst without moving the round-robin pointer
        step(4'b1000, 4'b0000, 32'h3000_0000, 1'b0, 1'b0);
        expect_beat(3, 8'h30);
        step(4'b1000, 4'b0000, 32'h3100_0000, 1'b0, 1'b0);
        expect_beat(3, 8'h31);
        chk("t4_locked", {31'd0, o_locked}, 1);
        step(4'b1000, 4'b0000, 32'h3200_0000, 1'b1, 1'b0);
        chk("t4_flush_we", {31'd0, o_fifo_we}, 0);
        chk("t4_flush_ready", {28'd0, o_req_ready}, 0);
        step(4'b0101, 4'b0101, 32'h00A2_00A0, 1'b0, 1'b0);
        expect_beat(2, 8'hA2);
        chk("t4_post_locked", {31'd0, o_locked}, 0);
        step(4'b0101, 4'b0101, 32'h00A2_00A0, 1'b0, 1'b0);
        expect_beat(0, 8'hA0);
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);

        // Locked req2 goes idle; lock holds and req0 starves until req2 finishes
        step(4'b0100, 4'b0000, 32'h0040_0000, 1'b0, 1'b0);
        expect_beat(2, 8'h40);
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 4'b0001, 32'h0000_00A0, 1'b0, 1'b0);
            chk("t5_hold_we", {31'd0, o_fifo_we}, 0);
            chk("t5_hold_locked", {31'd0, o_locked}, 1);
            chk("t5_hold_grant", {30'd0, o_grant_idx}, 2);
        end
        step(4'b0101, 4'b0101, 32'h0041_00A0, 1'b0, 1'b0);
        expect_beat(2, 8'h41);
        step(4'b0001, 4'b0001, 32'h0000_00A0, 1'b0, 1'b0);
        expect_beat(0, 8'hA0);
        chk("t5_idle_locked", {31'd0, o_locked}, 0);
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk("pending_beats", exp_q.size(), 0);

`ifdef PCYN_FIFO_WR_ARB_STATS_EN
        n_rst = 1'b0;
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_rst = 1'b1;
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk("stats_rst", o_beat_cnt[31:0], 0);
        for (int i = 0; i < 70000; i++) begin
            step(4'b0010, 4'b0010, 32'h0000_C100, 1'b0, 1'b0);
            expect_beat(1, 8'hC1);
        end
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk("stats_req0", {16'd0, o_beat_cnt[15:0]}, 0);
        chk("stats_req1", {16'd0, o_beat_cnt[31:16]}, 4464);
        chk("stats_req2", {16'd0, o_beat_cnt[47:32]}, 0);
        chk("stats_req3", {16'd0, o_beat_cnt[63:48]}, 0);
        step(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk("stats_pending", exp_q.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
